// File: rtl/csa_pkg.sv
// Shared definitions for the carry-skip adder sum stage: default width,
// status-flag bit positions and the skid buffer occupancy states.
package csa_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Bit positions inside the 3-bit {ovf, neg, zero} flags vector
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_W    = 3;

  // Occupancy of the two-entry (main + skid) output buffer
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/csa_skid_buf.sv
// Two-entry skid buffer (main + skid register) with a registered in_ready.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends combinationally on ready, ready is a
// flop, and the payload offered while out_valid is high holds until taken.
//
// Occupancy: EMPTY (nothing held), ONE (main full), FULL (main + skid full,
// in_ready low). The main register always feeds the output; when main is
// consumed in FULL, the skid entry moves into main on the same edge.
module csa_skid_buf
  import csa_pkg::*;
#(
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output skid_state_e   state_dbg
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q;
  logic          in_fire, out_fire;

  assign out_valid = (state_q != SKID_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign state_dbg = state_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  // Next occupancy and register contents from the two handshakes
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d = SKID_ONE;
          main_d  = in_data;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = SKID_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so the input side cannot fire
        if (out_fire) begin
          state_d = SKID_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
  end

  // State, payload and ready flops; reset empties both entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != SKID_FULL);
    end
  end

endmodule

// File: rtl/csa_sum_stage.sv
// Final sum stage of a carry-skip adder: combines the propagate vector with
// the group carry vector into sum/cout (plus optional status flags) and
// registers the result through a two-entry skid buffer.
//
// Build option: define CSA_SUM_FLAGS_EN to add the {ovf, neg, zero} flags
// port and its logic; without it the port and flag logic are absent.
module csa_sum_stage
  import csa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   P,
  input  logic [WIDTH:0]   Gi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_SUM_FLAGS_EN
  ,
  output logic [FLAG_W-1:0] flags
`endif
);

`ifdef CSA_SUM_FLAGS_EN
  localparam int PW = WIDTH + 1 + FLAG_W;
`else
  localparam int PW = WIDTH + 1;
`endif

  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic [PW-1:0]    pay_in, pay_out;
  skid_state_e      skid_state;
  logic             unused_ok;

  // P[0] is only the carry-in slot; the buffer state is for debug probing
  assign unused_ok = ^{P[0], skid_state};

  // Sum bit k takes the propagate of bit k (stored at P[k+1]) and the carry into bit k
  always_comb begin
    sum_c  = P[WIDTH:1] ^ Gi[WIDTH-1:0];
    cout_c = Gi[WIDTH];
  end

`ifdef CSA_SUM_FLAGS_EN
  logic [FLAG_W-1:0] flags_c;

  // Overflow is the carry into the MSB disagreeing with the carry out of it
  always_comb begin
    flags_c            = '0;
    flags_c[FLAG_ZERO] = (sum_c == '0);
    flags_c[FLAG_NEG]  = sum_c[WIDTH-1];
    flags_c[FLAG_OVF]  = Gi[WIDTH] ^ Gi[WIDTH-1];
  end

  assign pay_in                = {flags_c, cout_c, sum_c};
  assign {flags, cout, sum}    = pay_out;
`else
  assign pay_in                = {cout_c, sum_c};
  assign {cout, sum}           = pay_out;
`endif

  csa_skid_buf #(
    .DW (PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out),
    .state_dbg (skid_state)
  );

endmodule

// File: tb/tb_csa_sum_stage.sv
// Self-checking bench for csa_sum_stage (WIDTH = 16). Operands a, b, cin are
// turned into P/Gi with plain integer arithmetic; expected results come from
// a+b+cin and the signed-overflow rule, queued in exp_q and compared by a
// scoreboard on every output transfer. Flag checks follow CSA_SUM_FLAGS_EN.
module tb_csa_sum_stage;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   P;
  logic [W:0]   Gi;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CSA_SUM_FLAGS_EN
  logic [2:0]   flags;
`endif

  csa_sum_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .Gi        (Gi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSA_SUM_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  logic [W+3:0] exp_q[$];
  logic [W-1:0] cur_a, cur_b;
  logic         cur_cin;
  logic [W+3:0] mon_exp, mon_got;

  // Reference: {ovf, neg, zero, cout, sum} of a + b + cin
  function automatic logic [W+3:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin);
    logic [W:0]   t;
    logic [W-1:0] s;
    logic         ovf;
    t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    s   = t[W-1:0];
    ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {ovf, s[W-1], (s == '0), t[W], s};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands as P/Gi: Gi[k] is the carry into bit k of a + b + cin
  task automatic apply(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic ordy);
    logic [W:0]  p, g;
    int unsigned ai, bi, m;
    ai = a;
    bi = b;
    p[0] = 1'($urandom);
    for (int k = 0; k < W; k++) p[k+1] = a[k] ^ b[k];
    for (int k = 0; k <= W; k++) begin
      m    = (32'd1 << k) - 32'd1;
      g[k] = 1'((((ai & m) + (bi & m) + cin) >> k) & 32'd1);
    end
    cur_a     = a;
    cur_b     = b;
    cur_cin   = cin;
    P         = p;
    Gi        = g;
    in_valid  = iv;
    out_ready = ordy;
  endtask

  task automatic apply_rand(input logic iv, input logic ordy);
    apply(iv, W'($urandom), W'($urandom), 1'($urandom), ordy);
  endtask

  // Let the output drain with bounded waiting; a stuck output is a failure
  task automatic drain();
    int cyc;
    apply(1'b0, '0, '0, 1'b0, 1'b1);
    cyc = 0;
    while (out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (out_valid) begin
      n_fail++;
      $display("FAIL drain_timeout: out_valid still %b after %0d cycles, want 0", out_valid, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        n_tests++;
`ifdef CSA_SUM_FLAGS_EN
        mon_got = {flags, cout, sum};
`else
        mon_got = {3'b000, cout, sum};
`endif
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %h with empty expected queue", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          n_pop++;
`ifndef CSA_SUM_FLAGS_EN
          mon_exp[W+3:W+1] = 3'b000;
`endif
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_result: got %h want %h", mon_got, mon_exp);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_result(cur_a, cur_b, cur_cin));
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    apply(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if ({out_valid, in_ready, cout, sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid/ready/cout/sum = %b/%b/%b/%h want 0/0/0/0",
               out_valid, in_ready, cout, sum);
    end
`ifdef CSA_SUM_FLAGS_EN
    n_tests++;
    if (flags !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", flags);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_before_edge: got %b want 0", in_ready);
    end
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after_edge: got %b want 1", in_ready);
    end

    // Fill both entries, then reset mid-stream
    apply(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    apply(1'b1, 16'h4321, 16'h2222, 1'b1, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_tests++;
    if ({out_valid, in_ready, cout, sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream: valid/ready/cout/sum = %b/%b/%b/%h want 0/0/0/0",
               out_valid, in_ready, cout, sum);
    end
    apply(1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_discard: out_valid got %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_single();
    apply(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    tick();
    apply(1'b0, '0, '0, 1'b0, 1'b1);
    n_tests++;
    if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h0100}) begin
      n_fail++;
      $display("FAIL single_add: valid/cout/sum = %b/%b/%h want 1/0/0100", out_valid, cout, sum);
    end
`ifdef CSA_SUM_FLAGS_EN
    n_tests++;
    if (flags !== 3'b000) begin
      n_fail++;
      $display("FAIL single_flags: got %b want 000", flags);
    end
`endif
    drain();
  endtask

  task automatic test_wrap();
    apply(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    tick();
    apply(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    n_tests++;
    if ({out_valid, cout, sum} !== {1'b1, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL wrap_ffff: valid/cout/sum = %b/%b/%h want 1/1/0000", out_valid, cout, sum);
    end
`ifdef CSA_SUM_FLAGS_EN
    n_tests++;
    if (flags !== 3'b001) begin
      n_fail++;
      $display("FAIL wrap_ffff_flags: got %b want 001", flags);
    end
`endif
    tick();
    apply(1'b0, '0, '0, 1'b0, 1'b1);
    n_tests++;
    if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h8000}) begin
      n_fail++;
      $display("FAIL wrap_7fff: valid/cout/sum = %b/%b/%h want 1/0/8000", out_valid, cout, sum);
    end
`ifdef CSA_SUM_FLAGS_EN
    n_tests++;
    if (flags !== 3'b110) begin
      n_fail++;
      $display("FAIL wrap_7fff_flags: got %b want 110", flags);
    end
`endif
    drain();
  endtask

  task automatic test_backpressure();
    logic [W+3:0] first;
    logic [W-1:0] a0, b0;
    a0 = W'($urandom);
    b0 = W'($urandom);
    first = ref_result(a0, b0, 1'b1);
    apply(1'b1, a0, b0, 1'b1, 1'b0);
    tick();
    apply_rand(1'b1, 1'b0);
    tick();
    apply_rand(1'b1, 1'b0);
    tick();
    // Full now: more inputs offered must be ignored and the output must hold
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({in_ready, out_valid, cout, sum} !== {1'b0, 1'b1, first[W:0]}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ready/valid/cout/sum = %b/%b/%b/%h want 0/1/%b/%h",
                 i, in_ready, out_valid, cout, sum, first[W], first[W-1:0]);
      end
      n_tests++;
      if (exp_q.size() != 2) begin
        n_fail++;
        $display("FAIL bp_accepted[%0d]: got %0d entries want 2", i, exp_q.size());
      end
      apply_rand(1'b1, 1'b0);
      tick();
    end
    apply_rand(1'b1, 1'b1);
    tick();
    tick();
    drain();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: %0d results left, want 0", exp_q.size());
    end
  endtask

  task automatic test_streaming();
    int p0;
    p0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      apply_rand(1'b1, 1'b1);
      n_tests++;
      if (in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL stream_rate[%0d]: in_ready %b out_valid %b want 1 1", i, in_ready, out_valid);
      end
      tick();
    end
    drain();
    n_tests++;
    if (n_pop - p0 != 100) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results want 100", n_pop - p0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      tick();
    end
    drain();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: %0d results left, want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_streaming();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_sum_stage.md
CSA_SUM_STAGE -- requirements
Module: csa_sum_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the sum width in bits.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit, the reset; asynchronous, active-low.
REQ-004 The block SHALL have input in_valid, 1 bit, meaning upstream P/Gi are valid this cycle.
REQ-005 The block SHALL have output in_ready, 1 bit, meaning the block accepts P/Gi this cycle.
REQ-006 The block SHALL have input P, WIDTH+1 bits, the bitwise propagate vector; bit 0 is the carry-in slot and is ignored.
REQ-007 The block SHALL have input Gi, WIDTH+1 bits, the group generate (carry) vector from the carry-skip group PG network; Gi[0] is carry-in.
REQ-008 The block SHALL have output out_valid, 1 bit, meaning sum, cout and flags are valid.
REQ-009 The block SHALL have input out_ready, 1 bit, meaning downstream accepts the output this cycle.
REQ-010 The block SHALL have output sum, WIDTH bits, the registered sum.
REQ-011 The block SHALL have output cout, 1 bit, the registered carry-out.
REQ-012 The block SHALL have output flags, 3 bits {ovf, neg, zero}, the registered status flags (present only per REQ-028).

Function
REQ-013 The block SHALL compute sum[k] = P[k+1] XOR Gi[k] for k = 0..WIDTH-1, and cout = Gi[WIDTH].
REQ-014 The block SHALL compute zero = (sum == 0), neg = sum[WIDTH-1], and ovf = Gi[WIDTH] XOR Gi[WIDTH-1].
REQ-015 A transfer SHALL occur on an input when in_valid and in_ready are both high at a clock edge, and on the output when out_valid and out_ready are both high.
REQ-016 Results SHALL appear on the output registers with a latency of 1 cycle after an input transfer, when the output stage is empty or draining.
REQ-017 Buffering SHALL be a 2-entry skid buffer (main + skid); in_ready SHALL be registered and equal to NOT skid_full.
REQ-018 The state machine SHALL have exactly three states: EMPTY (out_valid=0), ONE (main full), and FULL (main+skid full, in_ready=0).
REQ-019 State transitions: EMPTY->ONE on input transfer; ONE->EMPTY on output transfer without input; ONE stays ONE on simultaneous in/out transfer; ONE->FULL on input without output; FULL->ONE on output transfer, with the skid entry moving to main in that same edge.
REQ-020 In FULL, P/Gi SHALL be ignored regardless of in_valid.
REQ-021 While out_valid is high and out_ready is low, sum, cout and flags SHALL hold stable.
REQ-022 Ordering SHALL be strictly FIFO; no result is dropped or duplicated.
REQ-023 in_valid=1 with Gi/P don't-care bit 0 SHALL NOT affect sum bit 0 other than via Gi[0].

Reset
REQ-024 Asserting rst_n low SHALL immediately force state EMPTY, out_valid=0, sum=0, cout=0, flags=0, with in_ready=0 while rst_n is low.
REQ-025 in_ready SHALL go to 1 on the first clock edge after rst_n deasserts.
REQ-026 Reset mid-transaction SHALL discard the main and skid contents with no output transfer.

Configuration
REQ-027 Flag generation SHALL be controlled by the macro CSA_SUM_FLAGS_EN.
REQ-028 With CSA_SUM_FLAGS_EN defined, the flags port and its registers SHALL exist per REQ-014; without it, the flags port SHALL be absent and no flag logic synthesized, with all other behaviour unchanged.

Structure
REQ-029 The shared package csa_pkg SHALL hold the flag index constants (FLAG_ZERO=0, FLAG_NEG=1, FLAG_OVF=2), the skid-state enum, and the default WIDTH constant.
REQ-030 The 2-entry handshake buffer SHALL be one sub-module csa_skid_buf, parameterised by payload width; the sum/flag logic SHALL stay in csa_sum_stage.

Verification
REQ-031 Reset test: rst_n low mid-stream -> out_valid=0, sum=0 immediately; in_ready=1 one edge after release.
REQ-032 Single add, WIDTH=16: P/Gi for 0x00FF+0x0001, cin=0 -> one cycle later sum=0x0100, cout=0, flags=000.
REQ-033 Wrap test: 0xFFFF+0x0001 -> sum=0x0000, cout=1, zero=1, ovf=0; 0x7FFF+0x0001 -> sum=0x8000, ovf=1, neg=1.
REQ-034 Backpressure test: out_ready=0 with 3 back-to-back inputs -> 2 accepted, in_ready=0, outputs stable; out_ready=1 -> results drain in order.
REQ-035 Streaming test: in_valid=out_ready=1 for 100 random operands -> one result per cycle, in order, matching the reference model.
REQ-036 Macro test: build without CSA_SUM_FLAGS_EN -> REQ-032 through REQ-035 pass with the flags checks removed.
